// File: rtl/msrv32_wb_unit_if.sv
// ---------------------------------------------------------------------------
// msrv32_wb_unit_if
//   Bundles every stage-3 writeback signal: the resolved instruction fields,
//   the data-memory load response, and the register-file write port.
//
//   master : stage-3 / memory side (drives the *_in signals, observes *_out)
//   slave  : the writeback unit   (consumes the *_in signals, drives *_out)
// ---------------------------------------------------------------------------
interface msrv32_wb_unit_if;
  // stage-3 instruction
  logic        wb_valid_in;
  logic [2:0]  wb_src_sel_in;
  logic        rf_wr_en_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_result_in;
  logic [31:0] imm_in;
  logic [31:0] pc_plus_4_in;
  logic [31:0] csr_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  addr_lsb_in;
  // data-memory load response
  logic        dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;
  // register-file write port and pipeline control
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic [31:0] rd_out;
  logic        stall_out;
  logic        load_fault_out;

  modport master (
    output wb_valid_in, wb_src_sel_in, rf_wr_en_in, rd_addr_in,
           alu_result_in, imm_in, pc_plus_4_in, csr_data_in,
           load_size_in, load_unsigned_in, addr_lsb_in,
           dmem_rvalid_in, dmem_rdata_in,
    input  rd_addr_out, wr_en_out, rd_out, stall_out, load_fault_out
  );

  modport slave (
    input  wb_valid_in, wb_src_sel_in, rf_wr_en_in, rd_addr_in,
           alu_result_in, imm_in, pc_plus_4_in, csr_data_in,
           load_size_in, load_unsigned_in, addr_lsb_in,
           dmem_rvalid_in, dmem_rdata_in,
    output rd_addr_out, wr_en_out, rd_out, stall_out, load_fault_out
  );
endinterface

// File: rtl/msrv32_wb_unit.sv
// ---------------------------------------------------------------------------
// msrv32_wb_unit
//   Pipeline stage-3 writeback. Selects the result source, aligns and
//   extends load data, and drives the integer register-file write port one
//   cycle after the write is resolved. A two-state FSM stalls the pipeline
//   while a load response is outstanding; a load that never returns is
//   aborted after LOAD_TIMEOUT waiting cycles with a one-cycle fault pulse.
//
//   Ports:
//     clock    : system clock, all state on the rising edge
//     reset_in : asynchronous, active-high reset
//     wb       : msrv32_wb_unit_if.slave (instruction, dmem response,
//                register-file write port, stall, load fault)
//
//   Parameter:
//     LOAD_TIMEOUT : WAIT_LOAD cycles without rvalid before abort (2..255)
// ---------------------------------------------------------------------------
module msrv32_wb_unit #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_in,
  msrv32_wb_unit_if.slave  wb
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  localparam logic [2:0] SRC_ALU  = 3'd0;
  localparam logic [2:0] SRC_LOAD = 3'd1;
  localparam logic [2:0] SRC_IMM  = 3'd2;
  localparam logic [2:0] SRC_PC4  = 3'd3;
  localparam logic [2:0] SRC_CSR  = 3'd4;

  localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;

  // Load fields captured when the load is accepted.
  logic [4:0]  ld_rd_q;
  logic        ld_wr_en_q;
  logic [1:0]  ld_size_q;
  logic        ld_unsigned_q;
  logic [1:0]  ld_lsb_q;

  // Registered write port.
  logic [4:0]  rd_addr_q;
  logic        wr_en_q;
  logic [31:0] rd_q;
  logic        fault_q;

  // Shift the addressed byte/half down to bit 0, then extend.
  function automatic logic [31:0] align_load(
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  lsb,
    input logic [31:0] raw
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh  = raw;
    res = raw;
    case (size)
      2'b00: begin
        sh  = raw >> {lsb, 3'b000};
        res = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        // Halfword position comes from lsb[1] only; lsb[0] is ignored.
        sh  = raw >> {lsb[1], 4'b0000};
        res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  logic        is_idle;
  logic [31:0] src_data;
  logic [31:0] load_data;
  logic        src_writes;

  assign is_idle = (state_q == IDLE);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src_data   = '0;
    src_writes = 1'b1;
    case (wb.wb_src_sel_in)
      SRC_ALU: src_data = wb.alu_result_in;
      SRC_IMM: src_data = wb.imm_in;
      SRC_PC4: src_data = wb.pc_plus_4_in;
      SRC_CSR: src_data = wb.csr_data_in;
      default: src_writes = 1'b0;
    endcase
  end

  // A zero-wait load aligns with the live inputs (they are being captured
  // this very cycle); a waited load uses the captured copy.
  always_comb begin
    load_data = '0;
    if (is_idle)
      load_data = align_load(wb.load_size_in, wb.load_unsigned_in,
                             wb.addr_lsb_in, wb.dmem_rdata_in);
    else
      load_data = align_load(ld_size_q, ld_unsigned_q,
                             ld_lsb_q, wb.dmem_rdata_in);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_rd_q       <= '0;
      ld_wr_en_q    <= 1'b0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      ld_lsb_q      <= '0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      rd_q          <= '0;
      fault_q       <= 1'b0;
    end else begin
      // Write enable and fault are single-cycle pulses.
      wr_en_q <= 1'b0;
      fault_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (wb.wb_valid_in) begin
            if (wb.wb_src_sel_in == SRC_LOAD) begin
              ld_rd_q       <= wb.rd_addr_in;
              ld_wr_en_q    <= wb.rf_wr_en_in;
              ld_size_q     <= wb.load_size_in;
              ld_unsigned_q <= wb.load_unsigned_in;
              ld_lsb_q      <= wb.addr_lsb_in;
              if (wb.dmem_rvalid_in) begin
                rd_addr_q <= wb.rd_addr_in;
                rd_q      <= load_data;
                wr_en_q   <= wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);
              end else begin
                state_q <= WAIT_LOAD;
                cnt_q   <= 8'd1;
              end
            end else if (src_writes) begin
              rd_addr_q <= wb.rd_addr_in;
              rd_q      <= src_data;
              wr_en_q   <= wb.rf_wr_en_in && (wb.rd_addr_in != 5'd0);
            end
          end
          // rvalid without an accepted load here is a stale response: ignored.
        end

        WAIT_LOAD: begin
          if (wb.dmem_rvalid_in) begin
            rd_addr_q <= ld_rd_q;
            rd_q      <= load_data;
            wr_en_q   <= ld_wr_en_q && (ld_rd_q != 5'd0);
            state_q   <= IDLE;
            cnt_q     <= '0;
          end else if (cnt_q == TIMEOUT_CNT) begin
            fault_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.rd_addr_out    = rd_addr_q;
  assign wb.wr_en_out      = wr_en_q;
  assign wb.rd_out         = rd_q;
  assign wb.load_fault_out = fault_q;
  // Stall releases in the cycle the response arrives so upstream advances
  // in step with the write being resolved.
  assign wb.stall_out      = (state_q == WAIT_LOAD) && !wb.dmem_rvalid_in;

endmodule
